// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the write-back/datapath source selector.
// Holds the occupancy state enum, the legacy source codes and sizing helpers.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } mux_sel_state_t;

    // Legacy write-back source codes of the multicycle core
    localparam int unsigned SEL_MEMDATA = 0;
    localparam int unsigned SEL_ALU     = 1;
    localparam int unsigned SEL_PC      = 2;
    localparam int unsigned SEL_ALUOUT  = 3;
    localparam int unsigned SEL_INST    = 4;
    localparam int unsigned SEL_EPC     = 5;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A stored beat is packed as {data, sel, err}
    function automatic int beat_width(input int width, input int sel_w);
        return width + sel_w + 1;
    endfunction

endpackage

// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle between upstream datapath sources, the selector and
// the write stage. master drives the beat inputs, slave is the selector.
interface mux_sel_pipe_if
    import mux_sel_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 8,
    parameter int SEL_W = sel_width(N_IN)
) ();

    logic [SEL_W-1:0]      sel;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_err;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err_clr;
    logic                  sel_err;

    modport master (
        output sel, in_data, in_valid, out_ready, err_clr,
        input  in_ready, out_data, out_sel, out_err, out_valid, sel_err
    );

    modport slave (
        input  sel, in_data, in_valid, out_ready, err_clr,
        output in_ready, out_data, out_sel, out_err, out_valid, sel_err
    );

endinterface

// File: rtl/mux_sel_comb.sv
// Pure combinational N-way select with range check; an out-of-range
// select yields DEFAULT_VAL and raises err.
module mux_sel_comb
    import mux_sel_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               N_IN        = 8,
    parameter int               SEL_W       = sel_width(N_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]      data,
    output logic                  err
);

    logic [WIDTH-1:0] ch [N_IN];

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
            assign ch[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Compare at 32 bits so a select wider than needed is still range-checked
    always_comb begin
        data = DEFAULT_VAL;
        err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (32'(sel) == 32'(k)) begin
                data = ch[k];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N-way selector with valid/ready handshake and a one-entry skid
// buffer; results are tagged with their select code and a range-error bit.
module mux_sel_pipe
    import mux_sel_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               N_IN        = 8,
    parameter int               SEL_W       = sel_width(N_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    mux_sel_pipe_if.slave bus
);

    localparam int BEAT_W = beat_width(WIDTH, SEL_W);

    mux_sel_state_t    state_q, state_d;
    logic [BEAT_W-1:0] or_q, or_d;
    logic [BEAT_W-1:0] sk_q, sk_d;
    logic              sel_err_q, sel_err_d;

    logic [WIDTH-1:0]  comb_data;
    logic              comb_err;
    logic [BEAT_W-1:0] beat;
    logic              accept;
    logic              drain;

    mux_sel_comb #(
        .WIDTH       (WIDTH),
        .N_IN        (N_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_comb (
        .sel     (bus.sel),
        .in_data (bus.in_data),
        .data    (comb_data),
        .err     (comb_err)
    );

    assign beat = {comb_data, bus.sel, comb_err};

    // Ready depends only on occupancy, never on out_ready, so no ready path crosses the block
    assign bus.in_ready = (state_q != TWO) && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = (state_q != EMPTY) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    or_d    = beat;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    or_d = beat;
                end else if (accept) begin
                    sk_d    = beat;
                    state_d = TWO;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    or_d    = sk_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // A new error wins over a simultaneous clear
    always_comb begin
        sel_err_d = sel_err_q;
        if (accept && comb_err) begin
            sel_err_d = 1'b1;
        end else if (bus.err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            or_q      <= '0;
            sk_q      <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            or_q      <= or_d;
            sk_q      <= sk_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign {bus.out_data, bus.out_sel, bus.out_err} = or_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: an 8-channel and a 6-channel instance share one
// stimulus stream and are checked against a queue-based reference model.
module tb_mux_sel_pipe;

    localparam logic [31:0] DEF6 = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  sel;
        logic        err;
    } beat_t;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] exp8;
        logic [31:0] exp6;
        logic        err6;
        logic        serr6;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mux_sel_pipe_if #(.WIDTH(32), .N_IN(8), .SEL_W(3)) i8 ();
    mux_sel_pipe_if #(.WIDTH(32), .N_IN(6), .SEL_W(3)) i6 ();

    mux_sel_pipe #(.WIDTH(32), .N_IN(8), .SEL_W(3), .DEFAULT_VAL(32'h0)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (i8)
    );

    mux_sel_pipe #(.WIDTH(32), .N_IN(6), .SEL_W(3), .DEFAULT_VAL(DEF6)) dut6 (
        .clk   (clk),
        .reset (reset),
        .bus   (i6)
    );

    logic [31:0] chan [8];
    beat_t       q8[$];
    beat_t       q6[$];
    logic        serr8_m = 1'b0;
    logic        serr6_m = 1'b0;
    int          n_vec   = 0;
    int          n_miss  = 0;
    int          n_acc   = 0;
    vec_t        tv [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic ordy, input logic clr);
        i8.in_valid  = v;    i6.in_valid  = v;
        i8.sel       = s;    i6.sel       = s;
        i8.out_ready = ordy; i6.out_ready = ordy;
        i8.err_clr   = clr;  i6.err_clr   = clr;
        for (int k = 0; k < 8; k++) i8.in_data[k*32 +: 32] = chan[k];
        for (int k = 0; k < 6; k++) i6.in_data[k*32 +: 32] = chan[k];
    endtask

    function automatic beat_t ref_beat(input int n, input logic [31:0] dflt, input logic [2:0] s);
        beat_t b;
        b.sel  = s;
        b.err  = (int'(s) >= n);
        b.data = b.err ? dflt : chan[s];
        return b;
    endfunction

    task automatic check_outputs();
        chk("out_valid8", 32'(i8.out_valid), 32'(q8.size() != 0));
        chk("in_ready8",  32'(i8.in_ready),  32'(q8.size() < 2));
        chk("sel_err8",   32'(i8.sel_err),   32'(serr8_m));
        if (q8.size() != 0) begin
            chk("out_data8", i8.out_data,          q8[0].data);
            chk("out_sel8",  32'(i8.out_sel),      32'(q8[0].sel));
            chk("out_err8",  32'(i8.out_err),      32'(q8[0].err));
        end
        chk("out_valid6", 32'(i6.out_valid), 32'(q6.size() != 0));
        chk("in_ready6",  32'(i6.in_ready),  32'(q6.size() < 2));
        chk("sel_err6",   32'(i6.sel_err),   32'(serr6_m));
        if (q6.size() != 0) begin
            chk("out_data6", i6.out_data,          q6[0].data);
            chk("out_sel6",  32'(i6.out_sel),      32'(q6[0].sel));
            chk("out_err6",  32'(i6.out_err),      32'(q6[0].err));
        end
    endtask

    // Model: each instance is a FIFO of at most two beats
    task automatic tick();
        beat_t b8, b6;
        logic  a8, a6, d8, d6, clr;
        a8  = i8.in_valid && (q8.size() < 2);
        a6  = i6.in_valid && (q6.size() < 2);
        d8  = (q8.size() != 0) && i8.out_ready;
        d6  = (q6.size() != 0) && i6.out_ready;
        clr = i8.err_clr;
        b8  = ref_beat(8, 32'h0, i8.sel);
        b6  = ref_beat(6, DEF6, i6.sel);
        @(posedge clk);
        if (d8) void'(q8.pop_front());
        if (a8) begin q8.push_back(b8); n_acc++; end
        if (d6) void'(q6.pop_front());
        if (a6) q6.push_back(b6);
        if (a8 && b8.err) serr8_m = 1'b1; else if (clr) serr8_m = 1'b0;
        if (a6 && b6.err) serr6_m = 1'b1; else if (clr) serr6_m = 1'b0;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) chan[k] = 32'h1000_0000 + 32'(k);
        drive(1'b0, 3'd0, 1'b0, 1'b0);

        tv[0] = '{3'd0, 32'h1000_0000, 32'h1000_0000, 1'b0, 1'b0};
        tv[1] = '{3'd1, 32'h1000_0001, 32'h1000_0001, 1'b0, 1'b0};
        tv[2] = '{3'd2, 32'h1000_0002, 32'h1000_0002, 1'b0, 1'b0};
        tv[3] = '{3'd3, 32'h1000_0003, 32'h1000_0003, 1'b0, 1'b0};
        tv[4] = '{3'd4, 32'h1000_0004, 32'h1000_0004, 1'b0, 1'b0};
        tv[5] = '{3'd5, 32'h1000_0005, 32'h1000_0005, 1'b0, 1'b0};
        tv[6] = '{3'd6, 32'h1000_0006, DEF6,          1'b1, 1'b1};
        tv[7] = '{3'd7, 32'h1000_0007, DEF6,          1'b1, 1'b1};
        tv[8] = '{3'd1, 32'h1000_0001, 32'h1000_0001, 1'b0, 1'b1};
        tv[9] = '{3'd2, 32'h1000_0002, 32'h1000_0002, 1'b0, 1'b1};

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        chk("rst_out_valid8", 32'(i8.out_valid), 32'd0);
        chk("rst_out_data8",  i8.out_data,       32'd0);
        chk("rst_out_sel8",   32'(i8.out_sel),   32'd0);
        chk("rst_out_err8",   32'(i8.out_err),   32'd0);
        chk("rst_sel_err8",   32'(i8.sel_err),   32'd0);
        chk("rst_in_ready8",  32'(i8.in_ready),  32'd0);
        chk("rst_out_data6",  i6.out_data,       32'd0);
        chk("rst_in_ready6",  32'(i6.in_ready),  32'd0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready8", 32'(i8.in_ready), 32'd1);
        chk("rel_in_ready6", 32'(i6.in_ready), 32'd1);
        tick();

        // Streaming and out-of-range via the vector table
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tv[i].sel, 1'b1, 1'b0);
            tick();
            chk("tbl_data8", i8.out_data,        tv[i].exp8);
            chk("tbl_data6", i6.out_data,        tv[i].exp6);
            chk("tbl_err6",  32'(i6.out_err),    32'(tv[i].err6));
            chk("tbl_sel6",  32'(i6.out_sel),    32'(tv[i].sel));
            chk("tbl_serr6", 32'(i6.sel_err),    32'(tv[i].serr6));
            $display("vec %0d sel=%0d out8=%h out6=%h err6=%0b sel_err6=%0b",
                     i, tv[i].sel, i8.out_data, i6.out_data, i6.out_err, i6.sel_err);
        end
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        tick();

        // Backpressure into the skid register
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd5, 1'b0, 1'b0);
        tick();
        chk("bp_in_ready", 32'(i8.in_ready), 32'd0);
        chk("bp_data",     i8.out_data,      32'h1000_0003);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        chk("bp_hold", i8.out_data, 32'h1000_0003);
        $display("backpressure: full, holding out8=%h", i8.out_data);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        chk("bp_second",   i8.out_data,      32'h1000_0005);
        chk("bp_ready_up", 32'(i8.in_ready), 32'd1);
        $display("backpressure: drained, out8=%h in_ready=%0b", i8.out_data, i8.in_ready);
        tick();
        chk("bp_empty", 32'(i8.out_valid), 32'd0);

        // Clear versus set in the same cycle
        drive(1'b0, 3'd0, 1'b1, 1'b1);
        tick();
        chk("clr_alone", 32'(i6.sel_err), 32'd0);
        drive(1'b1, 3'd6, 1'b1, 1'b1);
        tick();
        chk("clr_race",   32'(i6.sel_err), 32'd1);
        chk("race_data6", i6.out_data,     DEF6);
        $display("clear race: sel_err6=%0b out6=%h", i6.sel_err, i6.out_data);
        drive(1'b0, 3'd0, 1'b1, 1'b1);
        tick();
        chk("clr_after", 32'(i6.sel_err), 32'd0);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        tick();

        // Asynchronous reset with both registers full
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd7, 1'b0, 1'b0);
        tick();
        chk("mid_full", 32'(i8.in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_out_valid8", 32'(i8.out_valid), 32'd0);
        chk("mid_in_ready8",  32'(i8.in_ready),  32'd0);
        chk("mid_out_valid6", 32'(i6.out_valid), 32'd0);
        chk("mid_in_ready6",  32'(i6.in_ready),  32'd0);
        chk("mid_sel_err6",   32'(i6.sel_err),   32'd0);
        $display("mid-stream reset: out_valid8=%0b in_ready8=%0b", i8.out_valid, i8.in_ready);
        q8.delete();
        q6.delete();
        serr8_m = 1'b0;
        serr6_m = 1'b0;
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rel_ready8", 32'(i8.in_ready), 32'd1);
        tick();
        tick();

        // Random valid/ready traffic
        n_acc = 0;
        for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
            logic ordy;
            for (int k = 0; k < 8; k++) chan[k] = $urandom;
            if (((cyc / 64) % 2) == 0) ordy = ($urandom_range(0, 3) != 0);
            else                       ordy = ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ordy,
                  $urandom_range(0, 15) == 0);
            tick();
        end
        n_vec++;
        if (n_acc < 10000) begin
            n_miss++;
            $display("FAIL random_budget: accepted %0d beats, expected 10000", n_acc);
        end
        $display("random: %0d beats accepted", n_acc);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
